// File: rtl/apb_arbiter_pkg.sv
// apb_arb_pkg: shared types and constants for the APB requester arbiter.
//   apb_arb_state_e  - bus sequencer state (IDLE / SETUP / ACCESS)
//   APB_ARB_MAX_REQ  - largest supported requester count
//   rr_wrap_inc()    - modulo-n increment used to advance the round-robin pointer
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  localparam int unsigned APB_ARB_MAX_REQ = 16;

  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_arbiter_if.sv
// apb_bus_t: APB3 bus bundle.
//   master modport - drives PCLK/PRESETn/PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//                    samples PRDATA/PREADY/PSLVERR
//   slave modport  - the mirror image
interface apb_bus_t #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PCLK;
  logic                  PRESETn;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req - request vector (N_REQ)
//   ptr - index where the search starts
//   en  - search enable; no grant when low
//   gnt - one-hot grant (all zero when nothing wins)
//   idx - binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdxW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdxW-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IdxW-1:0]  idx
);

  logic            found;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Walk the requesters starting at ptr, wrapping at N_REQ; first hit wins.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand     = (32'(ptr) + i) % N_REQ;
      cand_idx = IdxW'(cand);
      if (en && !found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one APB master port among N_REQ hold-until-done requesters.
//   PCLK, PRESETn       - clock, asynchronous active-low reset
//   req_i/we_i          - per-requester request level and write flag
//   addr_i/wdata_i      - per-requester address and write data
//   done_o              - one-cycle one-hot completion pulse
//   rdata_o/err_o       - read data / slave error of the completed transfer
//   apb                 - APB master modport
// Optional feature macro: APB_ARB_TIMEOUT_EN - abort ACCESS after TIMEOUT wait cycles
// with err_o=1 and rdata_o=0. Without it ACCESS waits for PREADY indefinitely.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                PCLK,
  input  logic                                PRESETn,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ-1:0]                    we_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]    wdata_i,
  output logic [N_REQ-1:0]                    done_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                err_o,
  apb_bus_t.master                            apb
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  apb_arb_state_e state_q, state_d;

  logic [IdxW-1:0]       idx_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [IdxW-1:0]       ptr_q;
  logic [N_REQ-1:0]      done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [N_REQ-1:0] req_masked;
  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic             psel;
  logic             penable;
  logic             complete;
  logic             timeout_hit;

  // A requester completing this cycle still shows req high; never re-grant it.
  assign req_masked = req_i & ~done_q;
  assign gnt_valid  = |gnt;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req (req_masked),
    .ptr (ptr_q),
    .en  (state_q == IDLE),
    .gnt (gnt),
    .idx (gnt_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] wait_cnt_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !apb.PREADY) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th stalled ACCESS cycle, i.e. as the count reaches TIMEOUT.
  assign timeout_hit = (state_q == ACCESS) && !apb.PREADY &&
                       (wait_cnt_q == CntW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    psel     = 1'b0;
    penable  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      SETUP: psel = 1'b1;
      ACCESS: begin
        psel     = 1'b1;
        penable  = 1'b1;
        complete = apb.PREADY || timeout_hit;
      end
      default: ;
    endcase
  end

  // Request latch, completion results and RR pointer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && gnt_valid) begin
        idx_q   <= gnt_idx;
        we_q    <= we_i[gnt_idx];
        addr_q  <= addr_i[gnt_idx];
        wdata_q <= wdata_i[gnt_idx];
      end
      done_q <= complete ? (N_REQ'(1) << idx_q) : '0;
      if (complete) begin
        if (!apb.PREADY) begin
          // Timeout abort: no valid slave response.
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          rdata_q <= we_q ? '0 : apb.PRDATA;
          err_q   <= apb.PSLVERR;
        end
        ptr_q <= IdxW'(rr_wrap_inc(32'(idx_q), N_REQ));
      end
    end
  end

  assign apb.PCLK    = PCLK;
  assign apb.PRESETn = PRESETn;
  assign apb.PSEL    = psel;
  assign apb.PENABLE = penable;
  // Latched registers only change on a grant, so the bus holds its last values when idle.
  assign apb.PWRITE  = we_q;
  assign apb.PADDR   = addr_q;
  assign apb.PWDATA  = wdata_q;

  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule
